reg_file: RTL and testbench
===========================

REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter SP_INIT, default 32'h7FFFFFFC, reset value of register 29 ($sp).
REQ-002 Parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-003 clk  input  1  rising-edge clock, one clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 reg_write  input  1  write enable, sampled at rising edge of clk.
REQ-006 write_reg  input  5  write address.
REQ-007 write_data  input  32  write data, driven by the writeback select mux.
REQ-008 read_reg1  input  5  port-1 read address (rs).
REQ-009 read_reg2  input  5  port-2 read address (rt).
REQ-010 read_data1  output  32  port-1 data, feeds ALU operand A.
REQ-011 read_data2  output  32  port-2 data, feeds the ALU-source mux (in0) and store data.
REQ-012 dbg_addr  input  5  debug read address.
REQ-013 dbg_data  output  32  debug read data, same rules as the read ports, no bypass.

Function
REQ-014 Storage SHALL be 32 registers x 32 bits.
REQ-015 Writes SHALL occur only at the rising edge of clk, when reg_write=1 and write_reg!=0.
REQ-016 Register 0 SHALL always read 32'h0; writes to it SHALL be discarded without error.
REQ-017 Reads SHALL be combinational: read_dataN follows read_regN and storage within the same cycle, with zero latency.
REQ-018 With BYPASS=1, when reg_write=1, write_reg!=0 and write_reg==read_regN, read_dataN SHALL equal write_data in that cycle (write-first).
REQ-019 With BYPASS=0, the read ports SHALL return the stored value until the edge, and the new value from the next cycle on.
REQ-020 Both read ports SHALL be able to address the same register, and both SHALL receive the same value, including the bypassed value.
REQ-021 Bypass SHALL never apply to address 0, even when write_reg=0 and reg_write=1.
REQ-022 X or Z on write_data SHALL be stored as-is; no masking.
REQ-023 Unwritten registers SHALL hold their value indefinitely.

Reset
REQ-024 While rst=1, all registers SHALL be cleared to 0 immediately, without waiting for a clock edge, except register 29, which loads SP_INIT.
REQ-025 While rst=1, writes SHALL be suppressed and bypass SHALL be inhibited; read ports SHALL show the reset values.
REQ-026 If rst asserts mid-cycle while a write is pending, the write SHALL be lost.
REQ-027 After rst deasserts, the first rising edge SHALL accept a write.

Verification
REQ-028 Reset: assert rst for 2 cycles, then read every register on both ports -> 0 everywhere, and 32'h7FFFFFFC at address 29.
REQ-029 Write/read: write 32'hAAAAAAAA to $8 and 32'h55555555 to $9 on consecutive edges, then read_reg1=8, read_reg2=9 -> read_data1=AAAAAAAA, read_data2=55555555.
REQ-030 $zero: reg_write=1, write_reg=0, write_data=32'h12345678, read_reg1=0 -> read_data1=0 before and after the edge.
REQ-031 Bypass: $10 holds 32'h12345678; drive reg_write=1, write_reg=10, write_data=32'h87654321, read_reg1=read_reg2=10 -> both read 87654321 in the same cycle with BYPASS=1, and 12345678 until the edge with BYPASS=0.
REQ-032 Async reset mid-operation: $8=AAAAAAAA; pulse rst between clock edges -> read_data1 (read_reg1=8) drops to 0 without waiting for a clock edge; a write presented at the same time is not stored.
REQ-033 Disabled write: reg_write=0, write_reg=9, write_data=FFFFFFFF over 3 edges -> $9 unchanged.

Source files
------------

// File: rtl/reg_file.sv
// 32 x 32-bit register file with two combinational read ports, a debug read port,
// optional write-first forwarding, and async reset that seeds $sp.
module reg_file #(
    parameter logic [31:0] SP_INIT = 32'h7FFFFFFC,
    parameter bit          BYPASS  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_write,
    input  logic [4:0]  write_reg,
    input  logic [31:0] write_data,
    input  logic [4:0]  read_reg1,
    input  logic [4:0]  read_reg2,
    output logic [31:0] read_data1,
    output logic [31:0] read_data2,
    input  logic [4:0]  dbg_addr,
    output logic [31:0] dbg_data
);

    localparam int NUM_REGS = 32;
    localparam logic [4:0] SP_IDX = 5'd29;

    logic [NUM_REGS-1:0][31:0] regs_q, regs_d;
    logic                      wr_en;
    logic                      byp1, byp2;

    function automatic logic [NUM_REGS-1:0][31:0] reset_image();
        logic [NUM_REGS-1:0][31:0] img;
        img         = '0;
        img[SP_IDX] = SP_INIT;
        return img;
    endfunction

    function automatic logic [31:0] stored(input logic [NUM_REGS-1:0][31:0] regs,
                                           input logic [4:0] addr);
        return (addr == 5'd0) ? 32'h0 : regs[addr];
    endfunction

    assign wr_en = reg_write && (write_reg != 5'd0);

    always_comb begin
        regs_d = regs_q;
        if (wr_en) regs_d[write_reg] = write_data;
        regs_d[0] = 32'h0;
    end

    // Reset wins over any pending write: the flops are held at the reset image.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= reset_image();
        else     regs_q <= regs_d;
    end

    // Forwarding is suppressed during reset so the ports show reset values.
    always_comb begin
        byp1 = BYPASS && !rst && wr_en && (write_reg == read_reg1);
        byp2 = BYPASS && !rst && wr_en && (write_reg == read_reg2);
    end

    assign read_data1 = byp1 ? write_data : stored(regs_q, read_reg1);
    assign read_data2 = byp2 ? write_data : stored(regs_q, read_reg2);
    assign dbg_data   = stored(regs_q, dbg_addr);

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: bypass and no-bypass instances share stimulus;
// expected values are queued at drive time and popped when outputs are sampled.
module tb_reg_file;

    localparam logic [31:0] SP = 32'h7FFFFFFC;

    logic        clk, rst, reg_write;
    logic [4:0]  write_reg, read_reg1, read_reg2, dbg_addr;
    logic [31:0] write_data;
    logic [31:0] b1_rd1, b1_rd2, b1_dbg, b0_rd1, b0_rd2, b0_dbg;

    reg_file #(.SP_INIT(SP), .BYPASS(1'b1)) dut_b1 (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(b1_rd1), .read_data2(b1_rd2), .dbg_addr(dbg_addr), .dbg_data(b1_dbg));

    reg_file #(.SP_INIT(SP), .BYPASS(1'b0)) dut_b0 (
        .clk(clk), .rst(rst), .reg_write(reg_write), .write_reg(write_reg),
        .write_data(write_data), .read_reg1(read_reg1), .read_reg2(read_reg2),
        .read_data1(b0_rd1), .read_data2(b0_rd2), .dbg_addr(dbg_addr), .dbg_data(b0_dbg));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef enum int {B1_RD1, B1_RD2, B1_DBG, B0_RD1, B0_RD2, B0_DBG} port_e;
    typedef struct {
        string       tag;
        port_e       port;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] model [32];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    endtask

    task automatic push(input string tag, input port_e p, input logic [31:0] e);
        exp_t x;
        x.tag = tag; x.port = p; x.exp = e;
        sb.push_back(x);
    endtask

    function automatic logic [31:0] obs(input port_e p);
        case (p)
            B1_RD1:  return b1_rd1;
            B1_RD2:  return b1_rd2;
            B1_DBG:  return b1_dbg;
            B0_RD1:  return b0_rd1;
            B0_RD2:  return b0_rd2;
            default: return b0_dbg;
        endcase
    endfunction

    task automatic drain();
        exp_t x;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            chk(x.tag, obs(x.port), x.exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        model[29] = SP;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        reg_write = 1'b1; write_reg = a; write_data = d;
        @(posedge clk); #1;
        reg_write = 1'b0;
        if (a != 5'd0) model[a] = d;
    endtask

    initial begin
        rst = 1'b1; reg_write = 1'b0; write_reg = '0; write_data = '0;
        read_reg1 = '0; read_reg2 = '0; dbg_addr = '0;
        model_reset();

        // Reset held for two cycles, then sweep every address on all ports
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            read_reg1 = 5'(i); read_reg2 = 5'(i); dbg_addr = 5'(i);
            push("rst_rd1", B1_RD1, (i == 29) ? SP : 32'h0);
            push("rst_rd2", B1_RD2, (i == 29) ? SP : 32'h0);
            push("rst_dbg", B1_DBG, (i == 29) ? SP : 32'h0);
            push("rst_b0rd1", B0_RD1, (i == 29) ? SP : 32'h0);
            #1 drain();
        end

        // Consecutive writes then dual read
        wr(5'd8, 32'hAAAAAAAA);
        wr(5'd9, 32'h55555555);
        read_reg1 = 5'd8; read_reg2 = 5'd9;
        push("wr_rd1", B1_RD1, 32'hAAAAAAAA);
        push("wr_rd2", B1_RD2, 32'h55555555);
        push("wr_b0rd1", B0_RD1, 32'hAAAAAAAA);
        push("wr_b0rd2", B0_RD2, 32'h55555555);
        #1 drain();

        // $zero write: no bypass, nothing stored
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd0; write_data = 32'h12345678;
        read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_addr = 5'd0;
        push("zero_pre_rd1", B1_RD1, 32'h0);
        push("zero_pre_rd2", B1_RD2, 32'h0);
        #2 drain();
        @(posedge clk); #1;
        push("zero_post_rd1", B1_RD1, 32'h0);
        push("zero_post_dbg", B1_DBG, 32'h0);
        push("zero_post_b0", B0_RD1, 32'h0);
        drain();
        reg_write = 1'b0;

        // Bypass: same-cycle forwarding on both ports, none on debug / BYPASS=0
        wr(5'd10, 32'h12345678);
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd10; write_data = 32'h87654321;
        read_reg1 = 5'd10; read_reg2 = 5'd10; dbg_addr = 5'd10;
        push("byp_rd1", B1_RD1, 32'h87654321);
        push("byp_rd2", B1_RD2, 32'h87654321);
        push("byp_dbg", B1_DBG, 32'h12345678);
        push("nobyp_rd1", B0_RD1, 32'h12345678);
        push("nobyp_rd2", B0_RD2, 32'h12345678);
        #2 drain();
        @(posedge clk); #1;
        reg_write = 1'b0; model[10] = 32'h87654321;
        push("nobyp_post_rd1", B0_RD1, 32'h87654321);
        push("nobyp_post_rd2", B0_RD2, 32'h87654321);
        push("byp_post_rd1", B1_RD1, 32'h87654321);
        drain();

        // Disabled write over 3 edges
        @(negedge clk);
        reg_write = 1'b0; write_reg = 5'd9; write_data = 32'hFFFFFFFF;
        read_reg1 = 5'd9; read_reg2 = 5'd9; dbg_addr = 5'd9;
        repeat (3) @(posedge clk);
        #1;
        push("nowr_rd1", B1_RD1, 32'h55555555);
        push("nowr_dbg", B1_DBG, 32'h55555555);
        push("nowr_b0", B0_RD2, 32'h55555555);
        drain();

        // Async reset mid-cycle with a pending write to $9
        @(negedge clk);
        reg_write = 1'b1; write_reg = 5'd9; write_data = 32'hDEADBEEF;
        read_reg1 = 5'd8; read_reg2 = 5'd9; dbg_addr = 5'd29;
        #1 rst = 1'b1;
        push("arst_rd1", B1_RD1, 32'h0);
        push("arst_rd2_nobyp", B1_RD2, 32'h0);
        push("arst_sp", B1_DBG, SP);
        push("arst_b0rd1", B0_RD1, 32'h0);
        #1 drain();
        #1 rst = 1'b0; reg_write = 1'b0;
        model_reset();
        @(posedge clk); #1;
        push("arst_lost", B1_RD2, 32'h0);
        push("arst_lost_b0", B0_RD2, 32'h0);
        drain();

        // First edge after reset accepts a write
        wr(5'd9, 32'hCAFEF00D);
        read_reg2 = 5'd9;
        push("post_rst_wr", B1_RD2, 32'hCAFEF00D);
        push("post_rst_wr_b0", B0_RD2, 32'hCAFEF00D);
        #1 drain();

        // Random traffic against the model
        for (int it = 0; it < 60; it++) begin
            logic        we;
            logic [4:0]  wa, a1, a2, ad;
            logic [31:0] wd;
            @(negedge clk);
            we = 1'($urandom_range(0, 1));
            wa = 5'($urandom_range(0, 31));
            wd = $urandom;
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            ad = 5'($urandom_range(0, 31));
            reg_write = we; write_reg = wa; write_data = wd;
            read_reg1 = a1; read_reg2 = a2; dbg_addr = ad;
            push("rnd_rd1", B1_RD1, (we && wa != 0 && wa == a1) ? wd : model[a1]);
            push("rnd_rd2", B1_RD2, (we && wa != 0 && wa == a2) ? wd : model[a2]);
            push("rnd_dbg", B1_DBG, model[ad]);
            push("rnd_b0rd1", B0_RD1, model[a1]);
            push("rnd_b0rd2", B0_RD2, model[a2]);
            push("rnd_b0dbg", B0_DBG, model[ad]);
            #2 drain();
            @(posedge clk); #1;
            if (we && wa != 0) model[wa] = wd;
        end
        reg_write = 1'b0;

        // Final sweep: stored contents match on both instances
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            push("final_dbg", B1_DBG, model[i]);
            push("final_b0dbg", B0_DBG, model[i]);
            #1 drain();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
